// File: rtl/mux4_arb_pkg.sv
// Shared constants, FSM state type and the round-robin pick helper for mux4_rr_arbiter.
package mux4_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Returns {found, idx}. The scan runs from the farthest offset down to ptr itself,
   // so the requester closest to ptr (in wrap order) is the one that wins.
   function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [SEL_W-1:0]   ptr);
      logic [SEL_W-1:0] idx;
      logic [SEL_W:0]   res;
      res = 3'b000;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ptr + k[SEL_W-1:0];
         if (valid[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux4_word.sv
// Combinational 4:1 word multiplexer built from two levels of 2:1 selection.
module mux4_word
   import mux4_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [NUM_REQ*WIDTH-1:0] i_data,
   input  logic [SEL_W-1:0]         i_sel,
   output logic [WIDTH-1:0]         o_data
);

   logic [WIDTH-1:0] w_lo;
   logic [WIDTH-1:0] w_hi;

   assign w_lo   = i_sel[0] ? i_data[1*WIDTH +: WIDTH] : i_data[0*WIDTH +: WIDTH];
   assign w_hi   = i_sel[0] ? i_data[3*WIDTH +: WIDTH] : i_data[2*WIDTH +: WIDTH];
   assign o_data = i_sel[1] ? w_hi : w_lo;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux, with a registered valid/ready output stage.
// Optional per-requester grant counters are enabled by defining MUX4_ARB_STATS_EN.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int RST_PTR = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         out_sel
`ifdef MUX4_ARB_STATS_EN
   ,
   input  logic                     stats_clr,
   output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

   localparam logic [SEL_W-1:0] RST_PTR_L = RST_PTR[SEL_W-1:0];

   state_t             r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic [SEL_W-1:0]   r_out_sel;
   logic [SEL_W-1:0]   r_ptr;

   logic               w_load;
   logic [SEL_W:0]     w_pick;
   logic               w_grant_en;
   logic [SEL_W-1:0]   w_grant;
   logic [WIDTH-1:0]   w_mux_data;

   // The output register can take a new word when empty or being drained this edge.
   assign w_load     = ~r_out_valid | out_ready;
   assign w_pick     = rr_pick(req_valid, r_ptr);
   assign w_grant    = w_pick[SEL_W-1:0];
   assign w_grant_en = w_load & w_pick[SEL_W] & ~rst;

   mux4_word #(.WIDTH(WIDTH)) u_mux (
      .i_data (req_data),
      .i_sel  (w_grant),
      .o_data (w_mux_data)
   );

   // One-hot handshake to the winning requester, only on a loading edge.
   always_comb begin
      req_ready = 4'b0000;
      if (w_grant_en) begin
         req_ready[w_grant] = 1'b1;
      end else begin
         req_ready = 4'b0000;
      end
   end

   // Control FSM and registered output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_out_data  <= {WIDTH{1'b0}};
         r_out_sel   <= 2'b00;
         r_ptr       <= RST_PTR_L;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_en) begin
                  r_state     <= BUSY;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_mux_data;
                  r_out_sel   <= w_grant;
                  r_ptr       <= w_grant + 2'd1;
               end else begin
                  r_state     <= IDLE;
               end
            end
            BUSY: begin
               if (w_grant_en) begin
                  r_state     <= BUSY;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_mux_data;
                  r_out_sel   <= w_grant;
                  r_ptr       <= w_grant + 2'd1;
               end else if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end else begin
                  r_state     <= BUSY;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

`ifdef MUX4_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] r_cnt;

   // Per-requester grant counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= {(NUM_REQ*16){1'b0}};
      end else if (stats_clr) begin
         r_cnt <= {(NUM_REQ*16){1'b0}};
      end else if (w_grant_en) begin
         r_cnt[w_grant] <= r_cnt[w_grant] + 16'h0001;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed steps plus random traffic against
// a cycle-level reference model of the arbitration rules.
module tb_mux4_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
`ifdef MUX4_ARB_STATS_EN
   logic        stats_clr;
   logic [63:0] grant_cnt;
   int          m_cnt [4];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_valid;
   int m_data;
   int m_sel;
   int m_ptr;

   mux4_rr_arbiter #(.WIDTH(8), .RST_PTR(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
`ifdef MUX4_ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .grant_cnt (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_data  = 0;
      m_sel   = 0;
      m_ptr   = 0;
`ifdef MUX4_ARB_STATS_EN
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, {63'd0, out_valid}, (m_valid != 0) ? 64'd1 : 64'd0);
      chk({tag, ".out_data"},  {56'd0, out_data},  64'(m_data));
      chk({tag, ".out_sel"},   {62'd0, out_sel},   64'(m_sel));
`ifdef MUX4_ARB_STATS_EN
      for (int i = 0; i < 4; i++)
         chk({tag, ".grant_cnt"}, {48'd0, grant_cnt[i*16 +: 16]}, 64'(m_cnt[i]));
`endif
   endtask

   // One clock cycle: drive inputs, check the handshake, clock, check the outputs.
   task automatic cycle(input string tag, input logic [3:0] v, input logic [31:0] d, input logic ordy);
      int load;
      int g;
      logic [3:0] exp_rdy;
      req_valid = v;
      req_data  = d;
      out_ready = ordy;
      #1;
      load = (m_valid == 0 || ordy) ? 1 : 0;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      exp_rdy = (load != 0 && g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk({tag, ".req_ready"}, {60'd0, req_ready}, {60'd0, exp_rdy});
      @(posedge clk);
      #1;
      if (load != 0) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = (d >> (8 * g)) & 32'hFF;
            m_sel   = g;
            m_ptr   = (g + 1) % 4;
         end else begin
            m_valid = 0;
         end
      end
`ifdef MUX4_ARB_STATS_EN
      if (stats_clr) begin
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (load != 0 && g >= 0) begin
         m_cnt[g] = (m_cnt[g] + 1) % 65536;
      end
`endif
      check_outputs(tag);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      req_data  = 32'hA3A2A1A0;
      out_ready = 1'b1;
`ifdef MUX4_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      model_reset();
      #7;
      chk("reset.req_ready", {60'd0, req_ready}, 64'd0);
      check_outputs("reset");
      @(posedge clk);
      #1;
      chk("reset_hold.req_ready", {60'd0, req_ready}, 64'd0);
      rst = 1'b0;

      // first grant after release goes to requester 0, then strict rotation
      cycle("first_grant", 4'hF, 32'hA3A2A1A0, 1'b1);
      chk("first_grant.sel0", {62'd0, out_sel}, 64'd0);
      for (int i = 0; i < 7; i++) cycle("all_req", 4'hF, 32'hA3A2A1A0, 1'b1);
      chk("all_req.last_sel", {62'd0, out_sel}, 64'd3);

      // single requester 2 wins every cycle, pointer wrapping around it
      for (int i = 0; i < 6; i++) cycle("single2", 4'b0100, 32'h115C2233, 1'b1);
      chk("single2.data", {56'd0, out_data}, 64'h5C);

      // backpressure freezes everything, release grants old sel + 1
      cycle("bp_load", 4'hF, 32'h44332211, 1'b1);
      for (int i = 0; i < 5; i++) cycle("bp_hold", 4'hF, 32'h88776655, 1'b0);
      cycle("bp_release", 4'hF, 32'hCCBBAA99, 1'b1);

      // single request then none: valid drops after one cycle
      cycle("drain_one", 4'b0001, 32'h000000E1, 1'b1);
      cycle("drain_idle", 4'b0000, 32'h000000E2, 1'b1);
      chk("drain_idle.valid", {63'd0, out_valid}, 64'd0);
      cycle("idle_again", 4'b0000, 32'h000000E3, 1'b0);

      // reset mid-transfer drops the held word immediately
      cycle("pre_rst", 4'b1000, 32'h7E000000, 1'b0);
      req_valid = 4'hF;
      out_ready = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid_rst.req_ready", {60'd0, req_ready}, 64'd0);
      check_outputs("mid_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle("post_rst", 4'hF, 32'hD3D2D1D0, 1'b1);

`ifdef MUX4_ARB_STATS_EN
      for (int i = 0; i < 10; i++) cycle("stats_r1", 4'b0010, 32'h0000B100, 1'b1);
      chk("stats.ten", {48'd0, grant_cnt[16 +: 16]}, 64'(m_cnt[1]));
      stats_clr = 1'b1;
      cycle("stats_clr", 4'b0010, 32'h0000B200, 1'b1);
      stats_clr = 1'b0;
      chk("stats_clr.cnt1", {48'd0, grant_cnt[16 +: 16]}, 64'd0);
`endif

      // random traffic
      for (int i = 0; i < 300; i++) begin
`ifdef MUX4_ARB_STATS_EN
         stats_clr = ($urandom_range(0, 31) == 0);
`endif
         cycle("random", 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
